// File: rtl/x_multdiv_pkg.sv
// Shared opcodes, exception codes and FSM state type for the X-stage multiply/divide unit.
package x_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_MUL   = 3'd4;
  localparam logic [2:0] EXC_DIV   = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} xmd_state_t;

endpackage

// File: rtl/x_multdiv_iter.sv
// Iteration datapath on unsigned magnitudes: shift-add multiply or restoring divide, one step per cycle.
// X_MULTDIV_BOOTH4_EN switches the multiply step to radix-4 Booth (2 bits per step).
module x_multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 divMode,
  input  logic                 last,
  input  logic [WIDTH-1:0]     ldLo,
  input  logic [WIDTH-1:0]     ldOpnd,
  output logic [2*WIDTH-1:0]   accNext
);

`ifdef X_MULTDIV_BOOTH4_EN
  localparam int HW = WIDTH + 4;
`else
  localparam int HW = WIDTH;
`endif

  logic [HW-1:0]    hi, hiNxt;
  logic [WIDTH-1:0] lo, loNxt, opnd;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

`ifdef X_MULTDIV_BOOTH4_EN
  logic             qm1, qm1Nxt, mMsb;
  logic [HW-1:0]    ext, pp, sumB;
  assign ext = HW'(opnd);
`else
  logic [WIDTH:0]   sum;
  logic             unusedLast;
  assign unusedLast = last;
`endif

  always_comb begin
    hiNxt   = hi;
    loNxt   = lo;
    sh      = '0;
    diff    = '0;
    ge      = 1'b0;
    accNext = '0;
`ifdef X_MULTDIV_BOOTH4_EN
    qm1Nxt  = qm1;
    pp      = '0;
    sumB    = '0;
`else
    sum     = '0;
`endif
    if (divMode) begin
      // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
      sh      = {hi[WIDTH-1:0], lo[WIDTH-1]};
      ge      = sh >= {1'b0, opnd};
      diff    = sh[WIDTH-1:0] - opnd;
      hiNxt   = HW'(ge ? diff : sh[WIDTH-1:0]);
      loNxt   = {lo[WIDTH-2:0], ge};
      accNext = {hiNxt[WIDTH-1:0], loNxt};
    end else begin
`ifdef X_MULTDIV_BOOTH4_EN
      case ({lo[1:0], qm1})
        3'b001, 3'b010: pp = ext;
        3'b011:         pp = ext << 1;
        3'b100:         pp = -(ext << 1);
        3'b101, 3'b110: pp = -ext;
        default:        pp = '0;
      endcase
      sumB    = hi + pp;
      hiNxt   = {{2{sumB[HW-1]}}, sumB[HW-1:2]};
      loNxt   = {sumB[1:0], lo[WIDTH-1:2]};
      qm1Nxt  = lo[1];
      // Booth reads the multiplier as signed; restore its weight-2^WIDTH bit on the final step.
      accNext = {hiNxt[WIDTH-1:0], loNxt}
              + ((last && mMsb) ? {opnd, {WIDTH{1'b0}}} : {2*WIDTH{1'b0}});
`else
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      hiNxt   = HW'(sum[WIDTH:1]);
      loNxt   = {sum[0], lo[WIDTH-1:1]};
      accNext = {hiNxt[WIDTH-1:0], loNxt};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
`ifdef X_MULTDIV_BOOTH4_EN
      qm1  <= 1'b0;
      mMsb <= 1'b0;
`endif
    end else if (load) begin
      hi   <= '0;
      lo   <= ldLo;
      opnd <= ldOpnd;
`ifdef X_MULTDIV_BOOTH4_EN
      qm1  <= 1'b0;
      mMsb <= ldLo[WIDTH-1];
`endif
    end else if (step) begin
      hi   <= hiNxt;
      lo   <= loNxt;
`ifdef X_MULTDIV_BOOTH4_EN
      qm1  <= qm1Nxt;
`endif
    end
  end

endmodule

// File: rtl/x_multdiv.sv
// Execute-stage multicycle signed mul/div: stalls the front end until a registered result is ready.
// Optional X_MULTDIV_BOOTH4_EN halves multiply iterations via radix-4 Booth.
module x_multdiv
  import x_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPC_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [31:0]      ins_x,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] b_x,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       exc_code
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
`ifdef X_MULTDIV_BOOTH4_EN
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
`else
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
`endif

  xmd_state_t         state, nextState;
  logic [CW-1:0]      cnt;
  logic               sgn;
  logic               startMul, startDiv, bZero, lastStep, ovf;
  logic [WIDTH-1:0]   magA, magB, quotS;
  logic [2*WIDTH-1:0] accNext, prodS;
  logic               unusedIns;

  assign unusedIns = ^{ins_x[31-OPC_W:2+OPC_W], ins_x[1:0]};

  assign startMul = (ins_x[31 -: OPC_W] == OPC_RTYPE) && (ins_x[2 +: OPC_W] == ALU_MUL);
  assign startDiv = (ins_x[31 -: OPC_W] == OPC_RTYPE) && (ins_x[2 +: OPC_W] == ALU_DIV);
  assign bZero    = (b_x == '0);

  // Two's-complement negate of the most negative value yields its exact unsigned magnitude.
  assign magA = a_x[WIDTH-1] ? -a_x : a_x;
  assign magB = b_x[WIDTH-1] ? -b_x : b_x;

  assign lastStep = ((state == MUL) && (cnt == MUL_LAST)) ||
                    ((state == DIV) && (cnt == DIV_LAST));

  x_multdiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .clr_n   (clr_n),
    .load    ((state == IDLE) && (startMul || startDiv)),
    .step    ((state == MUL) || (state == DIV)),
    .divMode (state == DIV),
    .last    (lastStep),
    .ldLo    (startDiv ? magA : magB),
    .ldOpnd  (startDiv ? magB : magA),
    .accNext (accNext)
  );

  assign prodS = sgn ? -accNext : accNext;
  assign quotS = sgn ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
  assign ovf   = prodS[2*WIDTH-1:WIDTH] != {WIDTH{prodS[WIDTH-1]}};

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        stall = startMul || startDiv;
        if (startMul)      nextState = MUL;
        else if (startDiv) nextState = bZero ? DONE : DIV;
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (lastStep) nextState = DONE;
      end
      // ins_x still holds the finished op here, so no decode.
      DONE: begin
        res_valid = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sgn      <= 1'b0;
      result   <= '0;
      exc_code <= EXC_NONE;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (startMul || startDiv) begin
            cnt <= '0;
            sgn <= a_x[WIDTH-1] ^ b_x[WIDTH-1];
            if (startDiv && bZero) begin
              result   <= '0;
              exc_code <= EXC_DIV;
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt + 1'b1;
          if (lastStep) begin
            if (state == MUL) begin
              result   <= prodS[WIDTH-1:0];
              exc_code <= ovf ? EXC_MUL : EXC_NONE;
            end else begin
              result   <= quotS;
              exc_code <= EXC_NONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_multdiv.sv
// Directed self-checking bench for x_multdiv: signs, overflow, divide-by-zero, back-to-back and mid-op reset.
module tb_x_multdiv;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] ins_x, a_x, b_x;
  logic        stall, res_valid;
  logic [31:0] result;
  logic [2:0]  exc_code;

  int errs   = 0;
  int checks = 0;

  localparam logic [31:0] MUL_I  = 32'h0000_0018;
  localparam logic [31:0] DIV_I  = 32'h0000_001C;
  localparam logic [31:0] ADD_I  = 32'h0043_0000;
  localparam logic [31:0] NRMUL  = 32'h0800_0018;
`ifdef X_MULTDIV_BOOTH4_EN
  localparam int MUL_STALL = 17;
`else
  localparam int MUL_STALL = 33;
`endif

  always #5 clk = ~clk;

  x_multdiv dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .ins_x     (ins_x),
    .a_x       (a_x),
    .b_x       (b_x),
    .stall     (stall),
    .res_valid (res_valid),
    .result    (result),
    .exc_code  (exc_code)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one op and follows it to its DONE cycle; leaves ins_x held through DONE.
  task automatic runOp(input string tag, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input int expStall,
                       input logic [31:0] expRes, input logic [2:0] expExc);
    int n;
    @(negedge clk);
    ins_x = ins; a_x = a; b_x = b;
    #1;
    chk({tag, ".rvlow"}, 64'(res_valid), 64'd0);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, ".stalls"}, 64'(n), 64'(expStall));
    chk({tag, ".rv"}, 64'(res_valid), 64'd1);
    chk({tag, ".res"}, 64'(result), 64'(expRes));
    chk({tag, ".exc"}, 64'(exc_code), 64'(expExc));
  endtask

  task automatic idleChk(input string tag, input logic [31:0] ins);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ins_x = ins; a_x = 32'd9; b_x = 32'd3;
      #1;
      chk({tag, ".stall"}, 64'(stall), 64'd0);
      chk({tag, ".rv"}, 64'(res_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n = 1'b0; ins_x = '0; a_x = '0; b_x = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.rv", 64'(res_valid), 64'd0);
    chk("rst.res", 64'(result), 64'd0);
    chk("rst.exc", 64'(exc_code), 64'd0);
    clr_n = 1'b1;

    runOp("mul7xm6",    MUL_I, 32'd7,          32'hFFFF_FFFA, MUL_STALL, 32'hFFFF_FFD6, 3'd0);
    runOp("mulovf",     MUL_I, 32'h0001_0000,  32'h0001_0000, MUL_STALL, 32'h0000_0000, 3'd4);
    runOp("mulm1m1",    MUL_I, 32'hFFFF_FFFF,  32'hFFFF_FFFF, MUL_STALL, 32'h0000_0001, 3'd0);
    runOp("mulmin1",    MUL_I, 32'h8000_0000,  32'h0000_0001, MUL_STALL, 32'h8000_0000, 3'd0);
    runOp("mulminm1",   MUL_I, 32'h8000_0000,  32'hFFFF_FFFF, MUL_STALL, 32'h8000_0000, 3'd4);
    runOp("divm7by2",   DIV_I, 32'hFFFF_FFF9,  32'd2,         33,        32'hFFFF_FFFD, 3'd0);
    runOp("divminbym1", DIV_I, 32'h8000_0000,  32'hFFFF_FFFF, 33,        32'h8000_0000, 3'd0);
    runOp("div5by0",    DIV_I, 32'd5,          32'd0,         1,         32'h0000_0000, 3'd5);

    idleChk("nop", 32'h0);
    idleChk("add", ADD_I);
    idleChk("nonrtype", NRMUL);

    runOp("b2b.mul", MUL_I, 32'd3,  32'd4, MUL_STALL, 32'd12, 3'd0);
    runOp("b2b.div", DIV_I, 32'd20, 32'd3, 33,        32'd6,  3'd0);

    @(negedge clk);
    ins_x = MUL_I; a_x = 32'h0001_2345; b_x = 32'h0000_6789;
    repeat (11) @(negedge clk);
    clr_n = 1'b0; ins_x = '0;
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("midrst.stall", 64'(stall), 64'd0);
    chk("midrst.rv", 64'(res_valid), 64'd0);
    chk("midrst.res", 64'(result), 64'd0);
    chk("midrst.exc", 64'(exc_code), 64'd0);
    idleChk("postrst", 32'h0);

    runOp("mul2x5", MUL_I, 32'd2, 32'd5, MUL_STALL, 32'd10, 3'd0);

    @(negedge clk);
    ins_x = '0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/x_multdiv.md
Name: x_multdiv

Overview:
- Execute-stage multicycle multiply/divide unit. It sits directly downstream of the D/X pipeline latch and consumes that latch's instruction and A/B operand outputs.
- On an R-type mul or div it stalls the front of the pipeline until a signed 32-bit result is ready.
- It then presents the result and any exception code to the X-stage result mux and the X/M latch.

Parameters:
- WIDTH, 32, operand/result width.
- OPC_W, 5, opcode field width (ins[31:27]) and ALU-op field width (ins[6:2]).

Ports:
- clk  in  1  pipeline clock, rising edge.
- clr_n  in  1  synchronous active-low reset.
- ins_x  in  32  instruction currently held in the D/X latch.
- a_x  in  32  operand A (rs value) from the D/X latch.
- b_x  in  32  operand B (rt value) from the D/X latch.
- stall  out  1  freezes the PC, F/D latch and D/X latch while high.
- res_valid  out  1  one-cycle pulse; result and exc_code are valid.
- result  out  32  signed quotient or low 32 bits of the product.
- exc_code  out  3  0 = none, 4 = mul overflow, 5 = divide by zero (written to rstatus downstream).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (clr_n).
- Reset (clr_n=0 at a rising edge):
  - state -> IDLE; counter, result and exc_code -> 0; res_valid -> 0.
  - Any operation in flight is abandoned. stall is low from the following cycle.
- Decode: start_mul = (ins_x[31:27]==00000) && (ins_x[6:2]==00110); start_div is the same with ins_x[6:2]==00111. All-zero nop never starts.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - stall = start_mul | start_div (combinational).
  - On start, latch |a_x|, |b_x| and the result sign (a[31]^b[31]), clear the 64-bit accumulator and set counter = 0.
  - Transitions: mul -> MUL. div with b_x != 0 -> DIV. div with b_x == 0 -> DONE with result = 0 and exc_code = 5.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle, 32 cycles, stall = 1. After the final iteration -> DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, 32 cycles, stall = 1. After the final iteration -> DONE.
- DONE:
  - stall = 0 and res_valid = 1; result and exc_code are registered on entry.
  - Sign is applied on entry to DONE: quotient truncates toward zero; the remainder is discarded.
  - Always -> IDLE next cycle. The same instruction is still in ins_x during DONE and must not restart.
- Latency:
  - mul/div: 33 stall cycles (detect + 32 iterations), result in cycle 34.
  - div by zero: 1 stall cycle, result in cycle 2.
- Mul overflow: set exc_code = 4 when the signed 64-bit product is not the sign-extension of its bit 31. result = low 32 bits regardless.
- Div of 0x80000000 by 0xFFFFFFFF: result = 0x80000000, exc_code = 0.
- |0x80000000| is handled as a 32-bit unsigned magnitude with no loss.
- result and exc_code hold their values between operations; downstream qualifies them with res_valid.
- Back-to-back: a mul/div arriving in ins_x in the cycle after DONE starts normally from IDLE.

Optional Feature:
- Macro: X_MULTDIV_BOOTH4_EN.
- When defined: MUL uses radix-4 Booth recoding, 2 bits per cycle, 16 iterations (17 stall cycles). Results and exceptions are identical.
- When undefined: radix-2 shift-add, 32 iterations, as above. DIV is unchanged in both builds.

Decomposition:
- Package x_pkg:
  - OPC_RTYPE = 5'b00000, ALU_MUL = 5'b00110, ALU_DIV = 5'b00111.
  - EXC_NONE = 0, EXC_MUL = 4, EXC_DIV = 5.
  - State enum xmd_state_t {IDLE, MUL, DIV, DONE}.
- One sub-module, x_multdiv_iter: holds the iteration datapath (accumulator, shift, add/subtract-restore), selected by a mode bit. FSM, counter, sign handling and overflow detection stay in the top level.

Test Plan:
- mul a=7, b=-6 -> stall high 33 cycles; res_valid pulse; result 0xFFFFFFD6 (-42); exc_code 0.
- mul 0x00010000 * 0x00010000 -> result 0x00000000, exc_code 4. Also -1 * -1 -> result 1, exc_code 0.
- div -7 / 2 -> result 0xFFFFFFFD (-3). Also 0x80000000 / -1 -> result 0x80000000, exc_code 0.
- div 5 / 0 -> stall 1 cycle; next cycle res_valid = 1, result 0, exc_code 5.
- mul 3*4 followed immediately by div 20/3 -> result 12 then 6. No restart of the mul in its DONE cycle. add/nop in ins_x -> stall never high.
- clr_n low for one edge at iteration 10 of a mul -> state IDLE, stall 0, result 0, no res_valid. A fresh mul 2*5 afterwards -> result 10.
